// File: rtl/prewish_mentor.sv
// prewish_mentor: upstream sequencer for the LED pattern blinker.
// Holds a small table of 8-bit LED masks and steps through it. Each mask
// is loaded into the blinker with a multi-cycle strobe. The controller then
// dwells for 2**DWELL_BITS cycles before loading the next mask, wrapping at
// the end of the table.
// Optional feature: define PREWISH_MENTOR_SYNC_EN to pass i_run through a
// 2-flop synchronizer. This adds 2 cycles of run latency.
module prewish_mentor #(
    parameter int ADDR_BITS  = 2,
    parameter int STB_CYCLES = 2,
    parameter int DWELL_BITS = 24
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [7:0]           i_wr_data,
    input  logic                 i_run,
    output logic                 STB_O,
    output logic [7:0]           DAT_O,
    output logic                 o_busy,
    output logic [ADDR_BITS-1:0] o_index
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int STB_W = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        DWELL
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [DEPTH-1:0][7:0]       mask_table;
    logic [STB_W-1:0]            stb_cnt;
    logic [DWELL_BITS-1:0]       dwell_cnt;
    logic [ADDR_BITS-1:0]        next_index;
    logic                        run_int;
    logic                        load_mask;
    logic                        advance;
    logic                        strobe_done;
    logic                        dwell_clear;

`ifdef PREWISH_MENTOR_SYNC_EN
    logic run_meta;
    logic run_sync;

    // Two-flop synchronizer so i_run may come from another clock domain
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
        end else begin
            run_meta <= i_run;
            run_sync <= run_meta;
        end
    end

    assign run_int = run_sync;
`else
    assign run_int = i_run;
`endif

    assign next_index = o_index + 1'b1;
    assign o_busy     = (state != IDLE);

    // Mask table: written in any state, reads on the same edge see the old entry
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            mask_table <= '0;
        end else if (i_wr_en) begin
            mask_table[i_wr_addr] <= i_wr_data;
        end
    end

    // State register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the datapath control strobes for this edge
    always_comb begin
        state_next  = state;
        load_mask   = 1'b0;
        advance     = 1'b0;
        strobe_done = 1'b0;
        dwell_clear = 1'b0;
        case (state)
            IDLE: begin
                if (run_int) begin
                    state_next = STROBE;
                    load_mask  = 1'b1;
                end
            end
            STROBE: begin
                if (stb_cnt == STB_LAST) begin
                    strobe_done = 1'b1;
                    state_next  = run_int ? DWELL : IDLE;
                end
            end
            DWELL: begin
                if (!run_int) begin
                    state_next  = IDLE;
                    dwell_clear = 1'b1;
                end else if (&dwell_cnt) begin
                    state_next = STROBE;
                    load_mask  = 1'b1;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Blinker interface and index: the mask is latched only when a load starts
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            STB_O   <= 1'b0;
            DAT_O   <= '0;
            o_index <= '0;
        end else if (load_mask) begin
            STB_O <= 1'b1;
            if (advance) begin
                o_index <= next_index;
                DAT_O   <= mask_table[next_index];
            end else begin
                DAT_O   <= mask_table[o_index];
            end
        end else if (strobe_done) begin
            STB_O <= 1'b0;
        end
    end

    // Strobe and dwell counters; each restarts from zero when its phase begins
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            stb_cnt   <= '0;
            dwell_cnt <= '0;
        end else begin
            if (load_mask) begin
                stb_cnt <= '0;
            end else if (state == STROBE) begin
                stb_cnt <= stb_cnt + 1'b1;
            end
            if (strobe_done || dwell_clear) begin
                dwell_cnt <= '0;
            end else if (state == DWELL) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule
